// File: rtl/stack_exec_unit.sv
// Memory-and-execute slice of the multicycle stack datapath: address mux, 32x8 memory, MDR,
// operand muxes, ALU and ALUout.
module stack_exec_unit #(
  parameter logic [7:0] PC_INC    = 8'd1,
  parameter string      INIT_FILE = "memory.mem"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IorD,
  input  logic [4:0] pc_addr,
  input  logic [4:0] ir_addr,
  input  logic       memread,
  input  logic       memwrite,
  input  logic [7:0] wdata,
  input  logic       ALUsrcA,
  input  logic [1:0] ALUsrcB,
  input  logic [1:0] aluop,
  input  logic [7:0] a_in,
  input  logic [7:0] tos_data,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_out,
  output logic [2:0] opcode,
  output logic [7:0] mdr_out,
  output logic [7:0] alu_result,
  output logic       zero,
  output logic [7:0] alu_out
);

  typedef enum logic [1:0] {AluAdd = 2'b00, AluSub = 2'b01, AluAnd = 2'b10, AluNot = 2'b11}
    alu_op_e;

  // Memory is not touched by rst.
  logic [7:0] mem [32] = '{default: 8'h00};

  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] mdr_q;
  logic [7:0] alu_q;

  always_comb begin
    mem_addr = IorD ? ir_addr : pc_addr;
    mem_out  = memread ? mem[mem_addr] : 8'h00;
    opcode   = mem_out[7:5];
  end

  always_ff @(posedge clk) begin
    if (memwrite) begin
      mem[mem_addr] <= wdata;
    end
  end

  always_comb begin
    op_a = ALUsrcA ? a_in : {3'b000, mem_addr};
    unique case (ALUsrcB)
      2'b00:   op_b = tos_data;
      2'b01:   op_b = PC_INC;
      default: op_b = 8'h00;
    endcase
  end

  always_comb begin
    unique case (alu_op_e'(aluop))
      AluAdd:  alu_result = op_a + op_b;
      AluSub:  alu_result = op_a - op_b;
      AluAnd:  alu_result = op_a & op_b;
      AluNot:  alu_result = ~op_a;
      default: alu_result = 8'h00;
    endcase
    zero = (alu_result == 8'h00);
  end

  // Both capture registers load unconditionally every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdr_q <= 8'h00;
      alu_q <= 8'h00;
    end else begin
      mdr_q <= mem_out;
      alu_q <= alu_result;
    end
  end

  assign mdr_out = mdr_q;
  assign alu_out = alu_q;

endmodule

// File: tb/tb_stack_exec_unit.sv
// Directed self-checking bench for stack_exec_unit.
module tb_stack_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       IorD;
  logic [4:0] pc_addr;
  logic [4:0] ir_addr;
  logic       memread;
  logic       memwrite;
  logic [7:0] wdata;
  logic       ALUsrcA;
  logic [1:0] ALUsrcB;
  logic [1:0] aluop;
  logic [7:0] a_in;
  logic [7:0] tos_data;
  logic [4:0] mem_addr;
  logic [7:0] mem_out;
  logic [2:0] opcode;
  logic [7:0] mdr_out;
  logic [7:0] alu_result;
  logic       zero;
  logic [7:0] alu_out;

  int n_tests = 0;
  int n_fail  = 0;

  stack_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .IorD       (IorD),
    .pc_addr    (pc_addr),
    .ir_addr    (ir_addr),
    .memread    (memread),
    .memwrite   (memwrite),
    .wdata      (wdata),
    .ALUsrcA    (ALUsrcA),
    .ALUsrcB    (ALUsrcB),
    .aluop      (aluop),
    .a_in       (a_in),
    .tos_data   (tos_data),
    .mem_addr   (mem_addr),
    .mem_out    (mem_out),
    .opcode     (opcode),
    .mdr_out    (mdr_out),
    .alu_result (alu_result),
    .zero       (zero),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Settle combinational logic, check result/zero, then check ALUout one edge later.
  task automatic alu_step(input string tag, input logic [1:0] op, input logic [7:0] exp,
                          input logic exp_z);
    aluop = op;
    #1;
    check({tag, "_result"}, alu_result, exp);
    check({tag, "_zero"}, {7'd0, zero}, {7'd0, exp_z});
    tick();
    check({tag, "_aluout"}, alu_out, exp);
  endtask

  initial begin
    rst = 1'b0; IorD = 1'b0; pc_addr = '0; ir_addr = '0; memread = 1'b0; memwrite = 1'b0;
    wdata = '0; ALUsrcA = 1'b0; ALUsrcB = 2'b00; aluop = 2'b00; a_in = '0; tos_data = '0;

    // Preload mem[3] before reset.
    IorD = 1'b1; ir_addr = 5'd3; wdata = 8'h3C; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;

    // Reset with live ALU input, plus a write that must still land.
    ALUsrcA = 1'b1; a_in = 8'h11; tos_data = 8'h22;
    ir_addr = 5'd20; wdata = 8'h77; memwrite = 1'b1; memread = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; memwrite = 1'b0; memread = 1'b0;
    check("reset_mdr", mdr_out, 8'h00);
    check("reset_aluout", alu_out, 8'h00);
    check("comb_during_reset_free", alu_result, 8'h33);
    memread = 1'b1; ir_addr = 5'd3;
    #1;
    check("mem3_survives_reset", mem_out, 8'h3C);
    ir_addr = 5'd20;
    #1;
    check("write_during_reset", mem_out, 8'h77);

    // Write then read.
    memread = 1'b0; ir_addr = 5'd7; wdata = 8'hA5; memwrite = 1'b1;
    tick();
    memwrite = 1'b0; memread = 1'b1;
    #1;
    check("read_a5", mem_out, 8'hA5);
    check("opcode_a5", {5'd0, opcode}, 8'd5);
    tick();
    check("mdr_a5", mdr_out, 8'hA5);

    // Read during write: old data until the edge.
    wdata = 8'h5A; memwrite = 1'b1;
    #1;
    check("rdw_old", mem_out, 8'hA5);
    tick();
    memwrite = 1'b0;
    check("rdw_new", mem_out, 8'h5A);
    check("mdr_old_value", mdr_out, 8'hA5);

    // Read disabled and address mux.
    memread = 1'b0; pc_addr = 5'd3; ir_addr = 5'd9; IorD = 1'b0;
    #1;
    check("rd_off_mem_out", mem_out, 8'h00);
    check("rd_off_opcode", {5'd0, opcode}, 8'h00);
    check("addr_pc", {3'd0, mem_addr}, 8'd3);
    IorD = 1'b1;
    #1;
    check("addr_ir", {3'd0, mem_addr}, 8'd9);
    tick();
    check("mdr_rd_off", mdr_out, 8'h00);

    // ALU operations.
    ALUsrcA = 1'b1; ALUsrcB = 2'b00; a_in = 8'h05; tos_data = 8'h05;
    alu_step("add", 2'b00, 8'h0A, 1'b0);
    alu_step("sub", 2'b01, 8'h00, 1'b1);
    alu_step("and", 2'b10, 8'h05, 1'b0);
    alu_step("not", 2'b11, 8'hFA, 1'b0);

    // Wrap-around.
    a_in = 8'hFF; tos_data = 8'h01;
    alu_step("add_wrap", 2'b00, 8'h00, 1'b1);
    a_in = 8'h00;
    alu_step("sub_wrap", 2'b01, 8'hFF, 1'b0);

    // PC increment path and constant-zero B selects.
    ALUsrcA = 1'b0; IorD = 1'b0; pc_addr = 5'd31; ALUsrcB = 2'b01;
    alu_step("pc_inc", 2'b00, 8'd32, 1'b0);
    ALUsrcB = 2'b10;
    alu_step("b_zero10", 2'b00, 8'd31, 1'b0);
    ALUsrcB = 2'b11;
    alu_step("b_zero11", 2'b01, 8'd31, 1'b0);

    // Reset priority over capture of a non-zero result.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_prio_aluout", alu_out, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
